banco_reg_param: RTL and testbench

Parametrised multi-port register file, the successor of the fixed 32×64, two-read/one-write register bank in the datapath. It provides NRD combinational read ports, one synchronous write port, an optional hardwired-zero register 0, and a sequential bulk-clear engine with a busy/done handshake. It sits between decode (read addresses) and writeback (write port) in the processor datapath.

---
 rtl/banco_reg_param.sv | 141 ++++++++++++++
 tb/tb_banco_reg_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/banco_reg_param.sv
// Parametrised multi-port register file: NRD combinational read ports, one write port,
// optional hardwired-zero r0 and a sequential bulk-clear sweep. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module banco_reg_param #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    rd_data,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     wr_err
);

  localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_A  = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                wr_err_q, wr_err_d;
  logic                busy_q, clr_done_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic wr_ok_s, wr_drop_s, wr_eff_s, clr_acc_s;

  // Write qualification; depends only on inputs and state, never feeds the flag outputs combinationally
  always_comb begin
    wr_ok_s   = wr_en && (state_q != ST_CLEAR) && ({1'b0, wr_addr} < DEPTH_A);
    wr_drop_s = wr_en && !wr_ok_s;
    wr_eff_s  = wr_ok_s && !((ZERO_REG != 0) && (wr_addr == {ADDR_W{1'b0}}));
    clr_acc_s = clr_req && (state_q != ST_CLEAR);
  end

  // Clear FSM next-state, sweep counter and sticky drop flag
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    // a drop in the accepting cycle wins so the error is never silently lost
    wr_err_d = wr_drop_s ? 1'b1 : (clr_acc_s ? 1'b0 : wr_err_q);
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = {(ADDR_W+1){1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        if (cnt_q == LAST_A) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_DONE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = {(ADDR_W+1){1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {(ADDR_W+1){1'b0}};
      end
    endcase
  end

  // FSM state, counter and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {(ADDR_W+1){1'b0}};
      wr_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_err_q   <= wr_err_d;
      busy_q     <= (state_d == ST_CLEAR);
      clr_done_q <= (state_d == ST_DONE);
    end
  end

  // Storage array: sweep zeroing has priority, writes are already blocked while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (state_q == ST_CLEAR) begin
      mem_q[cnt_q[IDX_W-1:0]] <= {DATA_W{1'b0}};
    end else if (wr_eff_s) begin
      mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
    end else begin
      mem_q <= mem_q;
    end
  end

  // Independent combinational read ports
  always_comb begin
    rd_data = {(NRD*DATA_W){1'b0}};
    for (int p = 0; p < NRD; p++) begin
      if ({1'b0, rd_addr[p*ADDR_W +: ADDR_W]} >= DEPTH_A) begin
        rd_data[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if ((ZERO_REG != 0) && (rd_addr[p*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}})) begin
        rd_data[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
`ifdef REGFILE_BYPASS_EN
      end else if (wr_eff_s && (rd_addr[p*ADDR_W +: ADDR_W] == wr_addr)) begin
        rd_data[p*DATA_W +: DATA_W] = wr_data;
`endif
      end else begin
        rd_data[p*DATA_W +: DATA_W] = mem_q[rd_addr[p*ADDR_W +: IDX_W]];
      end
    end
  end

  assign busy     = busy_q;
  assign clr_done = clr_done_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_banco_reg_param.sv
// Self-checking bench for banco_reg_param: default instance plus a 4-port, 32-bit, 16-deep instance.
module tb_banco_reg_param;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [4:0]    wr_addr;
  logic [63:0]   wr_data;
  logic [9:0]    rd_addr;
  logic [127:0]  rd_data;
  logic          clr_req, busy, clr_done, wr_err;

  logic          wr_en2;
  logic [5:0]    wr_addr2;
  logic [31:0]   wr_data2;
  logic [23:0]   rd_addr2;
  logic [127:0]  rd_data2;
  logic          clr_req2, busy2, clr_done2, wr_err2;

  int            n_checks = 0;
  int            n_errs = 0;
  logic [63:0]   exp_q [$];
  logic [63:0]   model [32];
  int            nb;

  always #5 clk = ~clk;

  banco_reg_param u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .clr_req(clr_req), .busy(busy),
    .clr_done(clr_done), .wr_err(wr_err)
  );

  banco_reg_param #(.DATA_W(32), .ADDR_W(6), .DEPTH(16), .NRD(4), .ZERO_REG(0)) u_dut2 (
    .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .clr_req(clr_req2), .busy(busy2),
    .clr_done(clr_done2), .wr_err(wr_err2)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = ~obs;
    end
    check_val(tag, obs, e);
  endtask

  task automatic wr(input int a, input logic [63:0] d);
    wr_en   = 1'b1;
    wr_addr = a[4:0];
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic rd_pair(input string tag, input int a0, input int a1);
    logic [4:0] x0, x1;
    x0 = a0[4:0];
    x1 = a1[4:0];
    rd_addr = {x1, x0};
    exp_q.push_back(model[a0]);
    exp_q.push_back(model[a1]);
    #1;
    sb_check({tag, "_p0"}, rd_data[63:0]);
    sb_check({tag, "_p1"}, rd_data[127:64]);
    @(negedge clk);
  endtask

  // Start a clear and count busy cycles; optionally tracks reg 10 and drops a write at busy cycle drop_at
  task automatic run_clear(input bit chk10, input logic [63:0] old10, input int drop_at, output int n);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    rd_addr[4:0] = 5'd10;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!busy) break;
      if (n == 0) check_val("clr_err_cleared", wr_err, 64'd0);
      if (chk10) begin
        exp_q.push_back((n < 11) ? old10 : 64'd0);
        sb_check("clr_r10", rd_data[63:0]);
      end
      wr_en   = (n == drop_at);
      wr_addr = 5'd3;
      wr_data = 64'hAB;
      clr_req = (n == 5);
      n++;
      @(negedge clk);
    end
    wr_en   = 1'b0;
    clr_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 64'd0; rd_addr = 10'd0; clr_req = 1'b0;
    wr_en2 = 1'b0; wr_addr2 = 6'd0; wr_data2 = 32'd0; rd_addr2 = 24'd0; clr_req2 = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    #2;
    check_val("rst_busy", busy, 64'd0);
    check_val("rst_done", clr_done, 64'd0);
    check_val("rst_err", wr_err, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rd_pair("rst_rd", 3, 7);

    // fill reg k with k+1 and cross-read
    for (int k = 0; k < 32; k++) begin
      wr(k, 64'(k + 1));
      if (k != 0) model[k] = 64'(k + 1);
    end
    for (int k = 0; k < 32; k++) rd_pair("cross", k, 31 - k);

    // same-cycle write/read of address 5
    rd_addr[4:0] = 5'd5;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(64'hDEADBEEF);
`else
    exp_q.push_back(64'd6);
`endif
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEADBEEF;
    #1;
    sb_check("byp_same", rd_data[63:0]);
    @(negedge clk);
    wr_en = 1'b0;
    model[5] = 64'hDEADBEEF;
    exp_q.push_back(model[5]);
    #1;
    sb_check("byp_next", rd_data[63:0]);
    rd_addr[4:0] = 5'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'hAAAA;
    exp_q.push_back(64'd0);
    #1;
    sb_check("zero_fwd", rd_data[63:0]);
    @(negedge clk);
    wr_en = 1'b0;
    rd_pair("zero_after", 0, 1);

    // bulk clear of an all-0xFF array, write landing in the DONE cycle
    for (int k = 0; k < 32; k++) begin
      wr(k, 64'hFF);
      if (k != 0) model[k] = 64'hFF;
    end
    run_clear(1'b1, 64'hFF, -1, nb);
    check_val("clr_busy_len", 64'(nb), 64'd32);
    check_val("clr_done_pulse", clr_done, 64'd1);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h99;
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    check_val("clr_done_end", clr_done, 64'd0);
    check_val("clr_busy_end", busy, 64'd0);
    for (int k = 0; k < 32; k++) model[k] = 64'd0;
    model[9] = 64'h99;
    for (int k = 0; k < 32; k++) rd_pair("after_clr", k, 31 - k);

    // write dropped while busy
    wr(3, 64'h33);
    run_clear(1'b0, 64'd0, 20, nb);
    check_val("drop_busy_len", 64'(nb), 64'd32);
    check_val("drop_err_set", wr_err, 64'd1);
    for (int k = 0; k < 32; k++) model[k] = 64'd0;
    @(negedge clk);
    rd_pair("drop_r3", 3, 9);

    // reset in the middle of a sweep
    wr(20, 64'h55);
    wr(31, 64'h66);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    check_val("mid_busy", busy, 64'd1);
    check_val("mid_err_cleared", wr_err, 64'd0);
    rd_addr = {5'd31, 5'd20};
    rst = 1'b1;
    #1;
    check_val("abort_busy", busy, 64'd0);
    check_val("abort_done", clr_done, 64'd0);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    sb_check("abort_r20", rd_data[63:0]);
    sb_check("abort_r31", rd_data[127:64]);
    @(negedge clk);
    rst = 1'b0;
    run_clear(1'b0, 64'd0, -1, nb);
    check_val("post_rst_len", 64'(nb), 64'd32);
    check_val("post_rst_done", clr_done, 64'd1);

    // 4-port, 32-bit, 16-deep instance without a zero register
    @(negedge clk);
    wr_en2 = 1'b1; wr_addr2 = 6'd0; wr_data2 = 32'h1234;
    @(negedge clk);
    wr_addr2 = 6'd15; wr_data2 = 32'hF00D;
    @(negedge clk);
    wr_addr2 = 6'd8; wr_data2 = 32'h88;
    @(negedge clk);
    wr_addr2 = 6'd40; wr_data2 = 32'hBAD;
    @(negedge clk);
    wr_en2 = 1'b0;
    rd_addr2 = 24'd0;
    for (int p = 0; p < 4; p++) exp_q.push_back(64'h1234);
    #1;
    for (int p = 0; p < 4; p++) sb_check("p4_r0", 64'(rd_data2[p*32 +: 32]));
    check_val("p4_err", wr_err2, 64'd1);
    rd_addr2 = {6'd40, 6'd15, 6'd0, 6'd8};
    exp_q.push_back(64'h88);
    exp_q.push_back(64'h1234);
    exp_q.push_back(64'hF00D);
    exp_q.push_back(64'd0);
    #1;
    for (int p = 0; p < 4; p++) sb_check("p4_mix", 64'(rd_data2[p*32 +: 32]));
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
